// File: rtl/freq_div_pkg.sv
// ============================================================================
// Module   : freq_div_pkg
// Brief    : Shared state encoding and limits for the clock-divider controller
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package freq_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } state_t;

   localparam int MIN_DIV = 2;

endpackage

`default_nettype wire

// File: rtl/div_counter.sv
// ============================================================================
// Module   : div_counter
// Brief    : Programmable modulo counter; wrap marks the last count of a period
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic [WIDTH-1:0] modulus,
   output logic [WIDTH-1:0] cnt,
   output logic             wrap
);

   logic [WIDTH-1:0] r_cnt;

   assign cnt  = r_cnt;
   assign wrap = run && (r_cnt == (modulus - WIDTH'(1)));

   // Stopping the counter also rewinds it, so every restart begins a full period
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (!run || wrap) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + WIDTH'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/freq_div_ctrl.sv
// ============================================================================
// Module   : freq_div_ctrl
// Brief    : Run-time programmable clock divider; divisor changes land on period boundaries
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module freq_div_ctrl
   import freq_div_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int DEFAULT_DIV = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             cfg_valid,
   input  logic [WIDTH-1:0] cfg_div,
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic             div_clk,
   output logic             tick,
   output logic [WIDTH-1:0] active_div,
   output logic             pending
);

   state_t           r_state,      w_state_nx;
   logic [WIDTH-1:0] r_active_div, w_active_nx;
   logic [WIDTH-1:0] r_pend_div,   w_pend_nx;
   logic             r_div_clk,    w_div_clk_nx;
   logic             r_tick,       w_tick_nx;
   logic             r_cfg_err,    w_cfg_err_nx;

   logic             w_xfer;
   logic             w_bad;
   logic             w_good;
   logic             w_run;
   logic [WIDTH-1:0] w_cnt;
   logic             w_wrap;

   assign cfg_ready  = (r_state != PEND);
   assign pending    = (r_state == PEND);
   assign cfg_err    = r_cfg_err;
   assign div_clk    = r_div_clk;
   assign tick       = r_tick;
   assign active_div = r_active_div;

   assign w_xfer = cfg_valid && cfg_ready;
   assign w_bad  = w_xfer && (cfg_div < WIDTH'(MIN_DIV));
   assign w_good = w_xfer && !w_bad;
   assign w_run  = en && (r_state != IDLE);

   div_counter #(
      .WIDTH (WIDTH)
   ) u_div_counter (
      .clk     (clk),
      .rst     (rst),
      .run     (w_run),
      .modulus (r_active_div),
      .cnt     (w_cnt),
      .wrap    (w_wrap)
   );

   always_comb begin
      w_state_nx   = r_state;
      w_active_nx  = r_active_div;
      w_pend_nx    = r_pend_div;
      w_div_clk_nx = 1'b0;
      w_tick_nx    = 1'b0;
      w_cfg_err_nx = w_bad;
      case (r_state)
         IDLE: begin
            if (w_good) w_active_nx = cfg_div;
            if (en)     w_state_nx  = RUN;
         end
         RUN, PEND: begin
            if (!en) begin
               // No period is in flight once stopped, so any new divisor applies at once
               w_state_nx = IDLE;
               if (r_state == PEND) w_active_nx = r_pend_div;
               else if (w_good)     w_active_nx = cfg_div;
            end else begin
               w_div_clk_nx = (w_cnt < (r_active_div >> 1));
               w_tick_nx    = w_wrap;
               if ((r_state == PEND) && w_wrap) begin
                  w_active_nx = r_pend_div;
                  w_state_nx  = RUN;
               end
               if (w_good) begin
                  w_pend_nx  = cfg_div;
                  w_state_nx = PEND;
               end
            end
         end
         default: w_state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_active_div <= WIDTH'(DEFAULT_DIV);
         r_pend_div   <= '0;
         r_div_clk    <= 1'b0;
         r_tick       <= 1'b0;
         r_cfg_err    <= 1'b0;
      end else begin
         r_state      <= w_state_nx;
         r_active_div <= w_active_nx;
         r_pend_div   <= w_pend_nx;
         r_div_clk    <= w_div_clk_nx;
         r_tick       <= w_tick_nx;
         r_cfg_err    <= w_cfg_err_nx;
      end
   end

endmodule

`default_nettype wire

// File: doc/freq_div_ctrl.md
Name: freq_div_ctrl

Overview:
- Run-time programmable clock-divider controller.
- Owns a modulo counter and sequences divisor changes so they take effect only at a period boundary. No truncated or glitched output periods.
- Produces a registered divided clock and a one-cycle period tick for downstream logic.
- Divisor updates arrive from a CSR/host over a valid/ready handshake.

Parameters:
- WIDTH, 16, width of divisor and internal counter.
- DEFAULT_DIV, 2, divisor loaded at reset. Must be >= 2 and < 2**WIDTH.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  run enable. 0 = hold divider stopped.
- cfg_valid  in  1  new divisor offered.
- cfg_div  in  WIDTH  requested divisor.
- cfg_ready  out  1  controller can accept a divisor this cycle (combinational from state).
- cfg_err  out  1  one-cycle pulse: accepted request had cfg_div < 2 and was discarded.
- div_clk  out  1  divided clock, registered.
- tick  out  1  one-cycle pulse, registered, once per completed period.
- active_div  out  WIDTH  divisor currently in use.
- pending  out  1  a divisor is latched and waiting for a boundary.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, cnt=0, active_div=DEFAULT_DIV, pend_div=0.
  - div_clk=0, tick=0, cfg_err=0, pending=0.
- States:
  - IDLE: en=0, counter stopped.
  - RUN: counting, nothing pending.
  - PEND: counting, new divisor latched.
- Handshake:
  - Transfer occurs when cfg_valid && cfg_ready.
  - cfg_ready = (state != PEND).
  - cfg_div < 2 on transfer: no state change; cfg_err=1 next cycle.
- IDLE:
  - cnt held 0, div_clk=0, tick=0.
  - Valid transfer: active_div <= cfg_div next edge. State remains IDLE.
  - en=1: go RUN, cnt starts at 0 on the following edge.
- RUN/PEND counting:
  - Each edge: if cnt == active_div-1, then cnt<=0 and tick<=1; else cnt<=cnt+1 and tick<=0.
  - div_clk <= (cnt < active_div>>1). Odd divisors give high = floor(div/2) cycles, low = ceil(div/2).
  - Latency: div_clk follows cnt by one cycle.
- RUN, valid transfer: pend_div<=cfg_div, pending<=1, state<=PEND.
- PEND at wrap edge: active_div<=pend_div, pending<=0, state<=RUN. The new period starts with cnt=0 under the new divisor.
- Simultaneous transfer and wrap in RUN:
  - The wrap completes with the old divisor.
  - The request goes to PEND and applies at the next wrap. It is never applied mid-edge.
- en deassert in RUN/PEND:
  - Next edge: state<=IDLE, cnt<=0, div_clk<=0, tick<=0.
  - If PEND: active_div<=pend_div and pending<=0 (applied immediately, since no period is in flight).
- Re-enable: the first period is always a full active_div cycles.
- Counter width: cnt is WIDTH bits. active_div max 2**WIDTH-1, so cnt never overflows.
- rst mid-period: everything returns to reset values immediately. Any pending divisor is lost.

Decomposition:
- Package freq_div_pkg:
  - state enum {IDLE, RUN, PEND}.
  - constant MIN_DIV=2.
- Sub-module div_counter (WIDTH): programmable modulo counter.
  - Inputs: clk, rst, run, modulus.
  - Outputs: cnt, wrap.
- freq_div_ctrl holds the FSM, handshake, pending register and the output registers.

Test Plan:
- Reset, en=1, no cfg → DEFAULT_DIV=2: div_clk toggles 1,0,1,0…; tick every 2 cycles; active_div=2.
- In RUN at div=4, send cfg_div=6 with cnt=1:
  - pending=1 and cfg_ready=0 until the wrap.
  - First post-wrap period is 6 cycles (3 high, 3 low).
  - No 4-cycle period is truncated.
- Transfer cfg_div=5 on the exact wrap cycle (div=4):
  - One more 4-cycle period runs, then 5-cycle periods (2 high, 3 low).
  - tick spacing is 4 then 5.
- cfg_div=1 and cfg_div=0 in RUN:
  - cfg_err pulses once each.
  - active_div is unchanged, pending stays 0, output periods are unchanged.
- In PEND (div=8 running, 3 pending), drop en:
  - Next edge: IDLE, div_clk=0, active_div=3, pending=0.
  - Re-enable gives 3-cycle periods starting at cnt=0.
- Assert rst mid-period at div=7 with pending=10:
  - All outputs return to reset values asynchronously; active_div=DEFAULT_DIV.
  - After release with en=1, 2-cycle periods resume.
